// File: rtl/tester_pkg.sv
// rtl/tester_pkg.sv - shared widths and result-writer state encoding
package tester_pkg;

    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_RTF_WIDTH  = 24;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        FIN   = 3'd5
    } rw_state_t;

endpackage

// File: rtl/result_writer_if.sv
// rtl/result_writer_if.sv - memory write-master bus used by the result writer
interface result_writer_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  waitrequest;

    modport master (
        output address, byteenable, write, writedata,
        input  waitrequest
    );

    modport slave (
        input  address, byteenable, write, writedata,
        output waitrequest
    );
endinterface

// File: rtl/result_writer.sv
// rtl/result_writer.sv - drains result FIFO words into memory as two bus-width halves
module result_writer
    import tester_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int RTF_WIDTH  = DEF_RTF_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  max_words,
    input  logic                  flush,
    input  logic [RTF_WIDTH-1:0]  rfifo_dataq,
    input  logic                  rfifo_rdempty,
    output logic                  rfifo_rdreq,
    result_writer_if.master       mem,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  words_written
);

    rw_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [RTF_WIDTH-1:0]  held_q;
    logic [CNT_WIDTH-1:0]  ww_q;
    logic [CNT_WIDTH-1:0]  max_q;
    logic                  ovf_q;
    logic                  start_ok;
    logic                  hit_limit;

    assign start_ok  = start && (state_q == IDLE || state_q == FIN);
    assign hit_limit = (max_q != '0) && ((ww_q + CNT_WIDTH'(1)) == max_q);

    always_comb begin
        state_d     = state_q;
        rfifo_rdreq = 1'b0;
        case (state_q)
            IDLE:    if (start_ok) state_d = FETCH;
            FETCH: begin
                if (!rfifo_rdempty) begin
                    rfifo_rdreq = 1'b1;
                    state_d     = LATCH;
                end else if (flush) begin
                    state_d = FIN;
                end
            end
            LATCH:   state_d = WR_LO;
            WR_LO:   if (!mem.waitrequest) state_d = WR_HI;
            WR_HI:   if (!mem.waitrequest) state_d = hit_limit ? FIN : FETCH;
            FIN:     if (start_ok) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            held_q  <= '0;
            ww_q    <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                addr_q <= base_addr;
                max_q  <= max_words;
                ww_q   <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (state_q == LATCH)
                    held_q <= rfifo_dataq;
                // Address wraps naturally at 2^ADDR_WIDTH.
                if ((state_q == WR_LO || state_q == WR_HI) && !mem.waitrequest)
                    addr_q <= addr_q + ADDR_WIDTH'(BE_WIDTH);
                if (state_q == WR_HI && !mem.waitrequest)
                    ww_q <= ww_q + CNT_WIDTH'(1);
                if (state_q == FIN && !rfifo_rdempty)
                    ovf_q <= 1'b1;
            end
        end
    end

    // Bus strobes decode straight from the state register so reset drops write at once.
    always_comb begin
        mem.write      = 1'b0;
        mem.byteenable = '0;
        mem.writedata  = '0;
        if (state_q == WR_LO) begin
            mem.write      = 1'b1;
            mem.byteenable = '1;
            mem.writedata  = held_q[DATA_WIDTH-1:0];
        end else if (state_q == WR_HI) begin
            mem.write      = 1'b1;
            mem.byteenable = '1;
            mem.writedata  = DATA_WIDTH'(held_q[RTF_WIDTH-1:DATA_WIDTH]);
        end
    end

    assign mem.address   = addr_q;
    assign busy          = (state_q == FETCH) || (state_q == LATCH) ||
                           (state_q == WR_LO) || (state_q == WR_HI);
    assign done          = (state_q == FIN);
    assign overflow      = ovf_q || ((state_q == FIN) && !rfifo_rdempty);
    assign words_written = ww_q;

endmodule

// File: tb/tb_result_writer.sv
// tb/tb_result_writer.sv - directed self-checking bench for result_writer
module tb_result_writer;
    import tester_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [15:0] max_words = '0;
    logic        flush = 1'b0;
    logic [23:0] rfifo_dataq = '0;
    logic        rfifo_rdempty;
    logic        rfifo_rdreq;
    logic        busy, done, overflow;
    logic [15:0] words_written;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    result_writer_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .BE_WIDTH(2)) mem();

    result_writer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .max_words(max_words), .flush(flush), .rfifo_dataq(rfifo_dataq),
        .rfifo_rdempty(rfifo_rdempty), .rfifo_rdreq(rfifo_rdreq), .mem(mem),
        .busy(busy), .done(done), .overflow(overflow), .words_written(words_written)
    );

    // Show-ahead-free FIFO model: data appears the cycle after rdreq.
    logic [23:0] fifo_mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rfifo_rdempty = (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        if (rfifo_rdreq && wr_ptr != rd_ptr) begin
            rfifo_dataq <= fifo_mem[rd_ptr % 16];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    logic [19:0] log_addr [0:63];
    logic [15:0] log_data [0:63];
    int log_n = 0;

    always @(negedge clock) begin
        #2;
        if (reset_n && mem.write && !mem.waitrequest && log_n < 64) begin
            log_addr[log_n] = mem.address;
            log_data[log_n] = mem.writedata;
            log_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [23:0] w);
        fifo_mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    task automatic kick(input logic [19:0] b, input logic [15:0] m);
        @(negedge clock);
        start = 1'b1;
        base_addr = b;
        max_words = m;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic expect_wr(input string tag, input int idx, input logic [19:0] a, input logic [15:0] d);
        check({tag, "_addr"}, {12'd0, log_addr[idx]}, {12'd0, a});
        check({tag, "_data"}, {16'd0, log_data[idx]}, {16'd0, d});
    endtask

    initial begin
        int ls;
        int n;
        mem.waitrequest = 1'b0;

        #3;
        check("rst_address", {12'd0, mem.address}, 32'd0);
        check("rst_write", {31'd0, mem.write}, 32'd0);
        check("rst_writedata", {16'd0, mem.writedata}, 32'd0);
        check("rst_byteenable", {30'd0, mem.byteenable}, 32'd0);
        check("rst_flags", {28'd0, busy, done, overflow, rfifo_rdreq}, 32'd0);
        check("rst_words", {16'd0, words_written}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single result, then flush.
        ls = log_n;
        push(24'hABCDEF);
        flush = 1'b1;
        kick(20'h00100, 16'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(50);
        check("t1_nwr", log_n - ls, 32'd2);
        expect_wr("t1_w0", ls, 20'h00100, 16'hCDEF);
        expect_wr("t1_w1", ls + 1, 20'h00102, 16'h00AB);
        check("t1_done_busy", {30'd0, done, busy}, 32'd2);
        check("t1_words", {16'd0, words_written}, 32'd1);
        check("t1_ovf", {31'd0, overflow}, 32'd0);

        // Stall the low half for five cycles.
        flush = 1'b0;
        mem.waitrequest = 1'b1;
        ls = log_n;
        push(24'h123456);
        kick(20'h00200, 16'd0);
        n = 0;
        while (!mem.write && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            check("t2_hold_write", {31'd0, mem.write}, 32'd1);
            check("t2_hold_addr", {12'd0, mem.address}, 32'h00200);
            check("t2_hold_data", {16'd0, mem.writedata}, 32'h3456);
            check("t2_no_accept", log_n - ls, 32'd0);
        end
        mem.waitrequest = 1'b0;
        flush = 1'b1;
        wait_done(50);
        check("t2_nwr", log_n - ls, 32'd2);
        expect_wr("t2_w0", ls, 20'h00200, 16'h3456);
        expect_wr("t2_w1", ls + 1, 20'h00202, 16'h0012);

        // Word limit with data left behind.
        flush = 1'b0;
        ls = log_n;
        push(24'h111111);
        push(24'h222222);
        push(24'h333333);
        kick(20'h00300, 16'd2);
        wait_done(80);
        check("t3_nwr", log_n - ls, 32'd4);
        expect_wr("t3_w0", ls, 20'h00300, 16'h1111);
        expect_wr("t3_w1", ls + 1, 20'h00302, 16'h0011);
        expect_wr("t3_w2", ls + 2, 20'h00304, 16'h2222);
        expect_wr("t3_w3", ls + 3, 20'h00306, 16'h0022);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_words", {16'd0, words_written}, 32'd2);
        check("t3_left", wr_ptr - rd_ptr, 32'd1);
        wr_ptr = rd_ptr;

        // Address wrap at the top of memory.
        ls = log_n;
        push(24'h0A5A5A);
        flush = 1'b1;
        kick(20'hFFFFE, 16'd0);
        check("t4_restart", {30'd0, done, overflow}, 32'd0);
        wait_done(50);
        check("t4_nwr", log_n - ls, 32'd2);
        expect_wr("t4_w0", ls, 20'hFFFFE, 16'h5A5A);
        expect_wr("t4_w1", ls + 1, 20'h00000, 16'h000A);

        // Idle in FETCH on an empty FIFO; stray start is ignored.
        flush = 1'b0;
        ls = log_n;
        kick(20'h00400, 16'd0);
        check("t5_restart", {30'd0, done, busy}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 5) begin
                start = 1'b1;
                base_addr = 20'h00900;
            end else begin
                start = 1'b0;
            end
        end
        check("t5_wait_flags", {29'd0, busy, mem.write, rfifo_rdreq}, 32'd4);
        check("t5_wait_nwr", log_n - ls, 32'd0);
        push(24'h00BEEF);
        flush = 1'b1;
        wait_done(50);
        check("t5_nwr", log_n - ls, 32'd2);
        expect_wr("t5_w0", ls, 20'h00400, 16'hBEEF);
        expect_wr("t5_w1", ls + 1, 20'h00402, 16'h0000);

        // Reset in the middle of the high half.
        flush = 1'b0;
        push(24'h765432);
        kick(20'h00500, 16'd0);
        n = 0;
        while (!(mem.write && mem.address == 20'h00502) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t6_in_hi", {12'd0, mem.address}, 32'h00502);
        reset_n = 1'b0;
        #1;
        check("t6_rst_write", {31'd0, mem.write}, 32'd0);
        check("t6_rst_state", {30'd0, busy, done}, 32'd0);
        check("t6_rst_addr", {12'd0, mem.address}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wr_ptr = rd_ptr;
        ls = log_n;
        push(24'h0C0FFE);
        flush = 1'b1;
        kick(20'h00600, 16'd0);
        wait_done(50);
        check("t6_nwr", log_n - ls, 32'd2);
        expect_wr("t6_w0", ls, 20'h00600, 16'h0FFE);
        expect_wr("t6_w1", ls + 1, 20'h00602, 16'h000C);
        check("t6_words", {16'd0, words_written}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, memory byte-address width.
REQ-002 Parameter DATA_WIDTH, default 16, memory data width.
REQ-003 Parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 Parameter RTF_WIDTH, default 24, result-FIFO word width; SHALL satisfy DATA_WIDTH < RTF_WIDTH <= 2*DATA_WIDTH.
REQ-005 Parameter CNT_WIDTH, default 16, result-count width.
REQ-006 Port clock input 1: the single clock; all logic on its rising edge.
REQ-007 Port reset_n input 1: reset, asynchronous, active-low.
REQ-008 Port start input 1: one-cycle pulse; begins a run, ignored unless IDLE.
REQ-009 Port base_addr input ADDR_WIDTH: first byte address, sampled on accepted start.
REQ-010 Port max_words input CNT_WIDTH: result-word limit, sampled on accepted start; 0 means no limit.
REQ-011 Port flush input 1: level; high means no more results will be produced.
REQ-012 Port rfifo_dataq input RTF_WIDTH: result-FIFO read data, valid the cycle after rdreq.
REQ-013 Port rfifo_rdempty input 1: result FIFO empty.
REQ-014 Port rfifo_rdreq output 1: result-FIFO read request.
REQ-015 Port address output ADDR_WIDTH, byteenable output BE_WIDTH, write output 1, writedata output DATA_WIDTH, waitrequest input 1: memory write master.
REQ-016 Port busy output 1, done output 1, overflow output 1, words_written output CNT_WIDTH: status.

Function
REQ-017 States SHALL be IDLE, FETCH, LATCH, WR_LO, WR_HI, FIN.
REQ-018 IDLE + start: latch base_addr/max_words, clear words_written, overflow and done, go to FETCH.
REQ-019 FETCH: if rfifo_rdempty=0, assert rfifo_rdreq for exactly one cycle, go to LATCH; if empty and flush=1, go to FIN; else stay.
REQ-020 LATCH: capture rfifo_dataq into a holding register, go to WR_LO; rfifo_rdreq SHALL be 0.
REQ-021 WR_LO: write=1, writedata=held[DATA_WIDTH-1:0], byteenable all ones; hold all bus outputs stable while waitrequest=1; on waitrequest=0, address+=BE_WIDTH, go to WR_HI.
REQ-022 WR_HI: writedata=held[RTF_WIDTH-1:DATA_WIDTH] zero-extended, byteenable all ones; same waitrequest rule; on completion address+=BE_WIDTH, words_written+=1, go to FETCH, or to FIN if words_written reaches max_words (max_words != 0).
REQ-023 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (wrap silently).
REQ-024 In FIN with rfifo_rdempty=0 (limit reached, data remaining), overflow SHALL be 1.
REQ-025 FIN: done=1 (level), busy=0; return to IDLE on next start only, which restarts a run in the same cycle.
REQ-026 busy SHALL be 1 in FETCH, LATCH, WR_LO, WR_HI.
REQ-027 write SHALL be 1 only in WR_LO and WR_HI; never two results in flight.
REQ-028 Minimum throughput: one result per 4 cycles with waitrequest=0 and FIFO non-empty.
REQ-029 flush asserted mid-result SHALL not abort it; both halves complete first.
REQ-030 start while busy SHALL be ignored.

Reset
REQ-031 reset_n low SHALL force IDLE, and address, writedata, byteenable, holding register, words_written to 0; write, rfifo_rdreq, busy, done, overflow to 0.
REQ-032 Reset mid-write SHALL drop write immediately (asynchronously); no completion assumed.

Structure
REQ-033 State encoding and default widths SHALL live in shared package tester_pkg.
REQ-034 Single module; no sub-module required.
REQ-035 Instantiated beside test_controller on the same clock, sharing the memory bus through an external arbiter.

Verification
REQ-036 base_addr=0x00100, max_words=0, FIFO holds 0xABCDEF then flush=1 -> writes 0xCDEF @0x00100, 0x00AB @0x00102, done=1, words_written=1.
REQ-037 waitrequest high 5 cycles during WR_LO -> address/writedata/write stable all 5 cycles, single accepted write.
REQ-038 max_words=2, FIFO holds 3 words -> 4 writes, done=1, overflow=1, words_written=2, third word unread.
REQ-039 base_addr=0xFFFFE, one result -> writes at 0xFFFFE then 0x00000.
REQ-040 Empty FIFO, flush=0 for 20 cycles, then one word pushed and flush=1 -> stays FETCH, then writes 2 halves, done.
REQ-041 reset_n low during WR_HI -> write=0 immediately; after release start with new base_addr runs cleanly.
